// File: rtl/countdown_mmss.sv
// BCD MM:SS down-counter with load/start/stop control, a one-cycle done pulse
// on reaching 00:00, a sticky expired flag and optional auto-reload.
module countdown_mmss #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       done,
    output logic       expired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [7:0]  min_reg;
    logic [7:0]  sec_reg;
    logic [15:0] reload_reg;
    logic        running_reg;
    logic        done_reg;
    logic        expired_reg;

    logic [15:0] load_raw;
    logic [15:0] load_clamped;
    logic [15:0] count;
    logic [15:0] count_dec;
    logic [3:0]  borrow;
    logic        count_is_zero;
    logic        dec_is_zero;
    logic        reload_is_zero;
    logic        can_start;

    assign load_raw = {load_min, load_sec};
    assign count    = {min_reg, sec_reg};
    assign borrow[0] = 1'b1;

    // Digit order, low to high: sec ones, sec tens, min ones, min tens.
    // Tens digits top out at 5, ones digits at 9, for both clamping and borrow wrap.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] LIMIT = (gi % 2 == 1) ? 4'd5 : 4'd9;
            logic [3:0] digit;

            assign digit = count[gi*4 +: 4];

            assign load_clamped[gi*4 +: 4] =
                (load_raw[gi*4 +: 4] > LIMIT) ? LIMIT : load_raw[gi*4 +: 4];

            assign count_dec[gi*4 +: 4] =
                !borrow[gi]        ? digit :
                (digit == 4'd0)    ? LIMIT :
                                     digit - 4'd1;

            if (gi < 3) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] && (digit == 4'd0);
            end
        end
    endgenerate

    assign count_is_zero  = (count == 16'h0000);
    assign dec_is_zero    = (count_dec == 16'h0000);
    assign reload_is_zero = (reload_reg == 16'h0000);
    assign can_start      = ((state_reg == IDLE) || (state_reg == PAUSE)) && !count_is_zero;

    // A stop strobe consumes its cycle even when it has no effect, so it
    // always masks a coincident start; an ignored start does not mask a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            min_reg     <= 8'h00;
            sec_reg     <= 8'h00;
            reload_reg  <= 16'h0000;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                {min_reg, sec_reg} <= load_clamped;
                reload_reg         <= load_clamped;
                state_reg          <= IDLE;
                running_reg        <= 1'b0;
                expired_reg        <= 1'b0;
            end else if (stop) begin
                if (state_reg == RUN) begin
                    state_reg   <= PAUSE;
                    running_reg <= 1'b0;
                end
            end else if (start && can_start) begin
                state_reg   <= RUN;
                running_reg <= 1'b1;
            end else if (tick && (state_reg == RUN)) begin
                if (dec_is_zero) begin
                    done_reg <= 1'b1;
                    if (AUTO_RELOAD && !reload_is_zero) begin
                        {min_reg, sec_reg} <= reload_reg;
                    end else begin
                        {min_reg, sec_reg} <= 16'h0000;
                        state_reg          <= DONE;
                        running_reg        <= 1'b0;
                        expired_reg        <= 1'b1;
                    end
                end else begin
                    {min_reg, sec_reg} <= count_dec;
                end
            end
        end
    end

    assign min     = min_reg;
    assign sec     = sec_reg;
    assign running = running_reg;
    assign done    = done_reg;
    assign expired = expired_reg;

endmodule

// File: tb/tb_countdown_mmss.sv
// Bench for countdown_mmss: both AUTO_RELOAD settings run side by side against
// a seconds-count reference model, plus a vector table and hand-written sequences.
module tb_countdown_mmss;

    logic       clk = 1'b0;
    logic       reset, tick, load, start, stop;
    logic [7:0] load_min, load_sec;

    logic [7:0] min0, sec0, min1, sec1;
    logic       running0, done0, expired0;
    logic       running1, done1, expired1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    countdown_mmss #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .load_min(load_min), .load_sec(load_sec), .start(start), .stop(stop),
        .min(min0), .sec(sec0), .running(running0), .done(done0), .expired(expired0)
    );

    countdown_mmss #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .load_min(load_min), .load_sec(load_sec), .start(start), .stop(stop),
        .min(min1), .sec(sec1), .running(running1), .done(done1), .expired(expired1)
    );

    // Reference model: the count is a plain number of seconds.
    int m_total [2];
    int m_reload[2];
    bit m_run   [2];
    bit m_exp   [2];
    bit m_done  [2];

    function automatic int clamp_val(input logic [7:0] b);
        int t, o;
        t = int'(b[7:4]);
        o = int'(b[3:0]);
        if (t > 5) t = 5;
        if (o > 9) o = 9;
        return t * 10 + o;
    endfunction

    function automatic logic [15:0] to_bcd(input int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (reset) begin
                m_total[i] = 0; m_reload[i] = 0; m_run[i] = 1'b0; m_exp[i] = 1'b0;
            end else if (load) begin
                m_total[i]  = clamp_val(load_min) * 60 + clamp_val(load_sec);
                m_reload[i] = m_total[i];
                m_run[i]    = 1'b0;
                m_exp[i]    = 1'b0;
            end else if (stop) begin
                m_run[i] = 1'b0;
            end else if (start && !m_run[i] && m_total[i] != 0) begin
                m_run[i] = 1'b1;
            end else if (tick && m_run[i]) begin
                m_total[i] = m_total[i] - 1;
                if (m_total[i] == 0) begin
                    m_done[i] = 1'b1;
                    if (i == 1 && m_reload[i] != 0) begin
                        m_total[i] = m_reload[i];
                    end else begin
                        m_run[i] = 1'b0;
                        m_exp[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [18:0] obs(input int i);
        if (i == 0) return {min0, sec0, running0, done0, expired0};
        return {min1, sec1, running1, done1, expired1};
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got mm:ss=%h:%h run=%b done=%b exp=%b, want mm:ss=%h:%h run=%b done=%b exp=%b",
                     name, got[18:11], got[10:3], got[2], got[1], got[0],
                     exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                         input logic st, input logic sp, input logic tk);
        reset = r; load = ld; load_min = lm; load_sec = ls; start = st; stop = sp; tick = tk;
        model_update();
        @(posedge clk);
        #1;
        check("model_ar0", obs(0), {to_bcd(m_total[0]), m_run[0], m_done[0], m_exp[0]});
        check("model_ar1", obs(1), {to_bcd(m_total[1]), m_run[1], m_done[1], m_exp[1]});
    endtask

    function automatic logic [18:0] ex(input logic [7:0] m, input logic [7:0] s,
                                       input logic r, input logic d, input logic e);
        return {m, s, r, d, e};
    endfunction

    typedef struct {
        logic        ld;
        logic [7:0]  lm;
        logic [7:0]  ls;
        logic        st;
        logic        sp;
        logic        tk;
        logic [18:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                                input logic st, input logic sp, input logic tk,
                                input logic [7:0] em, input logic [7:0] es,
                                input logic er, input logic ed, input logic ee);
        vec_t v;
        v.ld = ld; v.lm = lm; v.ls = ls; v.st = st; v.sp = sp; v.tk = tk;
        v.exp = {em, es, er, ed, ee};
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        logic r, ld, st, sp, tk;
        logic [7:0] lm, ls;

        reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        load_min = 8'h00; load_sec = 8'h00;

        // Reset from power-up
        drive(1, 0, 8'h00, 8'h00, 0, 0, 0);
        drive(1, 0, 8'h00, 8'h00, 0, 0, 0);
        check("reset_ar0", obs(0), 19'h0);
        check("reset_ar1", obs(1), 19'h0);

        // 01:00 run to zero
        drive(0, 1, 8'h01, 8'h00, 0, 0, 0);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 0);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
        check("first_tick", obs(0), ex(8'h00, 8'h59, 1, 0, 0));
        for (int k = 0; k < 58; k++) drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
        check("one_left", obs(0), ex(8'h00, 8'h01, 1, 0, 0));
        drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
        check("zero_reach", obs(0), ex(8'h00, 8'h00, 0, 1, 1));
        check("ar1_reload_60", obs(1), ex(8'h01, 8'h00, 1, 1, 0));
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0);
        check("done_one_cycle", obs(0), ex(8'h00, 8'h00, 0, 0, 1));
        drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
        check("tick_in_done", obs(0), ex(8'h00, 8'h00, 0, 0, 1));
        drive(0, 0, 8'h00, 8'h00, 1, 0, 0);
        check("start_in_done", obs(0), ex(8'h00, 8'h00, 0, 0, 1));
        drive(0, 1, 8'h00, 8'h05, 0, 0, 0);
        check("load_clears_exp", obs(0), ex(8'h00, 8'h05, 0, 0, 0));

        // Reset mid-run
        drive(0, 0, 8'h00, 8'h00, 1, 0, 0);
        drive(1, 0, 8'h00, 8'h00, 0, 0, 1);
        drive(1, 0, 8'h00, 8'h00, 0, 0, 1);
        check("reset_midrun_ar0", obs(0), 19'h0);
        check("reset_midrun_ar1", obs(1), 19'h0);

        // Table: ld lm ls st sp tk -> min sec running done expired (AUTO_RELOAD=0)
        tbl.push_back(mk(1, 8'h10, 8'h00, 0, 0, 0, 8'h10, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h09, 8'h59, 1, 0, 0));
        tbl.push_back(mk(1, 8'h00, 8'h10, 0, 0, 0, 8'h00, 8'h10, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h10, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h09, 1, 0, 0));
        tbl.push_back(mk(1, 8'h00, 8'h30, 0, 0, 0, 8'h00, 8'h30, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h30, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h29, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h28, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h27, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h26, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h25, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h25, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h25, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h25, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h25, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h25, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h24, 1, 0, 0));
        tbl.push_back(mk(1, 8'h7A, 8'hFF, 0, 0, 0, 8'h59, 8'h59, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h59, 8'h59, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h59, 8'h58, 1, 0, 0));
        tbl.push_back(mk(1, 8'h12, 8'h34, 0, 0, 1, 8'h12, 8'h34, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h12, 8'h34, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 8'h69, 8'h5A, 0, 0, 0, 8'h59, 8'h59, 0, 0, 0));
        tbl.push_back(mk(1, 8'h09, 8'h60, 0, 0, 0, 8'h09, 8'h50, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h09, 8'h50, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 1, 1, 8'h09, 8'h50, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 1, 8'h09, 8'h50, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h09, 8'h49, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 1, 8'h09, 8'h48, 1, 0, 0));
        foreach (tbl[i]) begin
            drive(0, tbl[i].ld, tbl[i].lm, tbl[i].ls, tbl[i].st, tbl[i].sp, tbl[i].tk);
            check($sformatf("table_%0d", i), obs(0), tbl[i].exp);
        end

        // Auto-reload from 00:02
        drive(0, 1, 8'h00, 8'h02, 0, 0, 0);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 0);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
        check("ar1_tick1", obs(1), ex(8'h00, 8'h01, 1, 0, 0));
        drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
        check("ar1_done1", obs(1), ex(8'h00, 8'h02, 1, 1, 0));
        check("ar0_done", obs(0), ex(8'h00, 8'h00, 0, 1, 1));
        drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
        check("ar1_tick3", obs(1), ex(8'h00, 8'h01, 1, 0, 0));
        drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
        check("ar1_done2", obs(1), ex(8'h00, 8'h02, 1, 1, 0));

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 29) == 0);
            tk = 1'($urandom_range(0, 1));
            lm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ls = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h15));
            drive(r, ld, lm, ls, st, sp, tk);
        end

        drive(0, 0, 8'h00, 8'h00, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_mmss.md
Name: countdown_mmss

Overview:
- BCD minutes:seconds down-counter for the clock design; the count-down counterpart of the up-counting hour/minute digit counters.
- Loaded with an MM:SS value and decremented once per 1 Hz tick enable.
- Raises a one-cycle `done` pulse and a sticky `expired` flag when the count reaches 00:00.
- Sits beside the timekeeping counters and drives the same 7-segment/BCD display path and alarm logic.

Parameters:
AUTO_RELOAD, 0, when 1 the counter reloads the last loaded value on reaching 00:00 and keeps running.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle 1 Hz enable; the count decrements only on cycles where `tick`=1.
- load  input  1  one-cycle strobe; captures `load_min`/`load_sec`.
- load_min  input  8  BCD minutes to load; [7:4] tens, [3:0] ones.
- load_sec  input  8  BCD seconds to load; [7:4] tens, [3:0] ones.
- start  input  1  one-cycle strobe; begin or resume counting.
- stop  input  1  one-cycle strobe; pause counting.
- min  output  8  current BCD minutes.
- sec  output  8  current BCD seconds.
- running  output  1  high while in state RUN.
- done  output  1  one-cycle pulse when the count reaches 00:00.
- expired  output  1  sticky; high from zero-reach until `load` or `reset` (AUTO_RELOAD=0 only).

Behaviour:
- Reset (synchronous, highest priority):
  - State IDLE.
  - `min`=8'h00, `sec`=8'h00, reload register=16'h0000.
  - `running`=0, `done`=0, `expired`=0.
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSE: stopped mid-count.
  - DONE: reached zero.
- Command priority within one cycle: reset > load > stop > start > tick.
- load, accepted in any state:
  - Next cycle: `min`/`sec` = clamped load values, reload register updated, state IDLE, `expired`=0.
  - A coincident `tick` is ignored.
- Load clamping, per field:
  - tens digit >5 becomes 5.
  - ones digit >9 becomes 9.
  - Example: 8'h7A loads as 8'h59.
- start:
  - In IDLE or PAUSE with count ≠ 00:00 → RUN.
  - With count 00:00, or in RUN or DONE, start is ignored.
- stop: RUN → PAUSE. Ignored in other states.
- Decrement, in RUN with `tick`=1 (no load/stop that cycle):
  - `sec` ones: 0 → 9 and borrow, else decrement.
  - `sec` tens: on borrow, 0 → 5 and borrow, else decrement.
  - `min` ones: 0 → 9 and borrow.
  - `min` tens: 0 → 5.
  - Example: 10:00 → 09:59.
  - Output updates the cycle after the tick; latency is 1 clk.
- Zero reach: when a decrement yields 00:00, in the same registered update:
  - `done`=1 for exactly one cycle.
  - AUTO_RELOAD=0:
    - state DONE, `running`=0, `expired`=1.
    - `expired` holds until load or reset.
    - `min`/`sec` hold at 00:00.
  - AUTO_RELOAD=1:
    - `min`/`sec` = reload register, state stays RUN, `running` stays 1.
    - `expired` stays 0.
    - If the reload register is 00:00, the counter goes to DONE as in AUTO_RELOAD=0.
- Tick handling outside RUN: `tick` is ignored in IDLE, PAUSE and DONE; count is unchanged.
- Output timing:
  - `running` is registered and equals (state==RUN).
  - `done` is 0 on every cycle without a zero-reach.
- Reset mid-operation (any state) returns to the reset values on the next edge. No `done` is generated.

Test Plan:
1. Assert `reset` for 2 cycles, any prior state → `min`=00, `sec`=00, `running`=0, `done`=0, `expired`=0.
2. Load 01:00, start, 1 tick → 00:59. After 59 more ticks → 00:00, `done` high exactly one cycle, `expired`=1, `running`=0. A further tick leaves 00:00.
3. Load 10:00, start, 1 tick → 09:59. Load 00:10, start, 1 tick → 00:09.
4. Load 00:30, start, 5 ticks → 00:25. Stop, then 3 ticks → still 00:25, `running`=0. Start, 1 tick → 00:24.
5. Load with min=8'h7A, sec=8'hFF → 59:59. Load+tick in the same cycle during RUN → loaded value, IDLE, no decrement. Start at 00:00 → stays IDLE.
6. AUTO_RELOAD=1: load 00:02, start, 2 ticks → `done` pulse, count 00:02, `running`=1, `expired`=0. 2 more ticks → second `done` pulse.
